// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Optionally holds off all access while the RAM zeroes itself after reset.
`timescale 1ns/1ps
module sp_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH           = 6,
   parameter int unsigned DATA_WIDTH           = 32,
   parameter bit          INIT_MEMORY_ON_RESET = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   input  logic [2*DATA_WIDTH-1:0] req_wmask,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    init_busy,
   output logic                    ram_clk_en,
   output logic                    ram_rdw_en,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_data_in,
   output logic [DATA_WIDTH-1:0]   ram_data_mask_in,
   input  logic [DATA_WIDTH-1:0]   ram_data_out
);

   typedef enum logic {StInit, StRun} state_e;

   localparam state_e                  ResetState = INIT_MEMORY_ON_RESET ? StInit : StRun;
   localparam logic [ADDR_WIDTH-1:0]   CntLast    = '1;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    prio_q, prio_d;   // 1 = requester 1 wins a tie
   logic [1:0]              rsp_valid_q, rsp_valid_d;
   logic [1:0]              grant;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      prio_d           = prio_q;
      rsp_valid_d      = '0;
      grant            = '0;
      ram_clk_en       = 1'b0;
      ram_rdw_en       = 1'b0;
      ram_addr         = '0;
      ram_data_in      = '0;
      ram_data_mask_in = '0;

      if (state_q == StInit) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CntLast) begin
            state_d = StRun;
            cnt_d   = '0;
         end
      end else begin
         if (req_valid[0] && (!req_valid[1] || !prio_q)) begin
            grant = 2'b01;
         end else if (req_valid[1]) begin
            grant = 2'b10;
         end
      end

      // Outputs must read as idle for the whole reset cycle, not only after the edge.
      if (!rst_n) begin
         grant = '0;
      end

      if (grant[1]) begin
         ram_clk_en       = 1'b1;
         ram_rdw_en       = req_we[1];
         ram_addr         = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
         ram_data_in      = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
         ram_data_mask_in = req_wmask[2*DATA_WIDTH-1:DATA_WIDTH];
         prio_d           = 1'b0;
      end else if (grant[0]) begin
         ram_clk_en       = 1'b1;
         ram_rdw_en       = req_we[0];
         ram_addr         = req_addr[ADDR_WIDTH-1:0];
         ram_data_in      = req_wdata[DATA_WIDTH-1:0];
         ram_data_mask_in = req_wmask[DATA_WIDTH-1:0];
         prio_d           = 1'b1;
      end

      rsp_valid_d = grant & ~req_we;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ResetState;
         cnt_q       <= '0;
         prio_q      <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prio_q      <= prio_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign req_ready = grant;
   assign rsp_valid = rsp_valid_q & {2{rst_n}};
   assign rsp_rdata = (|rsp_valid) ? ram_data_out : '0;
   assign init_busy = rst_n ? (state_q == StInit) : INIT_MEMORY_ON_RESET;

endmodule
